// File: rtl/regfile_wb_sched_if.sv
// Handshake, hazard-query and register-file write bundle for regfile_wb_sched.
interface regfile_wb_sched_if #(
    parameter int XLEN = 64,
    parameter int AW   = 5
);
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            alu_valid;
    logic            alu_ready;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            wb_en;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [31:0]     busy_vec;

    // Decode/EXU/LSU side
    modport master (
        output issue_valid, issue_rd, rs1, rs2,
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  rs1_busy, rs2_busy, alu_ready, lsu_ready,
        input  wb_en, wb_rd, wb_data, busy_vec
    );

    // Scheduler side
    modport slave (
        input  issue_valid, issue_rd, rs1, rs2,
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output rs1_busy, rs2_busy, alu_ready, lsu_ready,
        output wb_en, wb_rd, wb_data, busy_vec
    );
endinterface

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler and scoreboard: round-robin arbitration of the
// register file write port between ALU and LSU, plus RAW busy tracking.
module regfile_wb_sched #(
    parameter int XLEN = 64,
    parameter int AW   = 5
) (
    input logic                clk,
    input logic                rst,
    regfile_wb_sched_if.slave  bus
);

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_t;

    grant_t          last_grant_q;
    grant_t          last_grant_d;
    logic            alu_gnt;
    logic            lsu_gnt;
    logic            xfer;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [31:0]     busy_q;
    logic [31:0]     busy_d;
    logic            wb_en_q;
    logic [AW-1:0]   wb_rd_q;
    logic [XLEN-1:0] wb_data_q;

    // Round-robin grant, write-port mux and scoreboard next state
    always_comb begin
        alu_gnt      = bus.alu_valid && (!bus.lsu_valid || last_grant_q == GRANT_LSU);
        lsu_gnt      = bus.lsu_valid && (!bus.alu_valid || last_grant_q == GRANT_ALU);
        xfer         = alu_gnt || lsu_gnt;
        sel_rd       = '0;
        sel_data     = '0;
        last_grant_d = last_grant_q;
        if (lsu_gnt) begin
            sel_rd       = bus.lsu_rd;
            sel_data     = bus.lsu_data;
            last_grant_d = GRANT_LSU;
        end else if (alu_gnt) begin
            sel_rd       = bus.alu_rd;
            sel_data     = bus.alu_data;
            last_grant_d = GRANT_ALU;
        end
        // Clear first, then set: a newly issued writer owns the register
        busy_d = busy_q;
        if (xfer) begin
            busy_d[sel_rd] = 1'b0;
        end
        if (bus.issue_valid && bus.issue_rd != '0) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Write-back register, grant history and scoreboard state
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GRANT_ALU;
            busy_q       <= '0;
            wb_en_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            wb_en_q      <= xfer && (sel_rd != '0);
            if (xfer) begin
                wb_rd_q   <= sel_rd;
                wb_data_q <= sel_data;
            end
        end
    end

    assign bus.alu_ready = alu_gnt;
    assign bus.lsu_ready = lsu_gnt;
    assign bus.wb_en     = wb_en_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.busy_vec  = busy_q;

    // Hazards also cover the value sitting in the write-back register
    assign bus.rs1_busy = (bus.rs1 != '0) &&
                          (busy_q[bus.rs1] || (wb_en_q && wb_rd_q == bus.rs1));
    assign bus.rs2_busy = (bus.rs2 != '0) &&
                          (busy_q[bus.rs2] || (wb_en_q && wb_rd_q == bus.rs2));

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed self-checking bench for regfile_wb_sched.
module tb_regfile_wb_sched;

    logic clk;
    logic rst;
    int unsigned n_total;
    int unsigned n_pass;

    regfile_wb_sched_if #(.XLEN(64), .AW(5)) bus ();

    regfile_wb_sched #(.XLEN(64), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.rs1         = '0;
        bus.rs2         = '0;
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = '0;
        bus.alu_data    = '0;
        bus.lsu_valid   = 1'b0;
        bus.lsu_rd      = '0;
        bus.lsu_data    = '0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        check("reset_wb_en",   64'(bus.wb_en),    64'd0);
        check("reset_wb_rd",   64'(bus.wb_rd),    64'd0);
        check("reset_wb_data", bus.wb_data,       64'd0);
        check("reset_busy",    64'(bus.busy_vec), 64'd0);

        // Single ALU request
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 64'h1234;
        #1;
        check("t1_alu_ready", 64'(bus.alu_ready), 64'd1);
        check("t1_lsu_ready", 64'(bus.lsu_ready), 64'd0);
        step();
        bus.alu_valid = 1'b0;
        #1;
        check("t1_wb_en",   64'(bus.wb_en), 64'd1);
        check("t1_wb_rd",   64'(bus.wb_rd), 64'd5);
        check("t1_wb_data", bus.wb_data,    64'h1234);
        step();
        check("t1_wb_en_off", 64'(bus.wb_en), 64'd0);
        check("t1_wb_rd_hold", 64'(bus.wb_rd), 64'd5);
        check("t1_wb_data_hold", bus.wb_data, 64'h1234);

        // Contention: LSU wins first, then strict alternation
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd3;
        bus.alu_data  = 64'hA0A0;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd4;
        bus.lsu_data  = 64'hB0B0;
        for (int unsigned i = 0; i < 4; i++) begin
            #1;
            check("t2_lsu_ready", 64'(bus.lsu_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
            check("t2_alu_ready", 64'(bus.alu_ready), (i % 2 == 0) ? 64'd0 : 64'd1);
            step();
            check("t2_wb_en", 64'(bus.wb_en), 64'd1);
            check("t2_wb_rd", 64'(bus.wb_rd), (i % 2 == 0) ? 64'd4 : 64'd3);
            check("t2_wb_data", bus.wb_data, (i % 2 == 0) ? 64'hB0B0 : 64'hA0A0);
        end
        idle_inputs();
        step();

        // Scoreboard tracking of rd 7 through the write-back stage
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        step();
        bus.issue_valid = 1'b0;
        bus.rs1 = 5'd7;
        bus.rs2 = 5'd6;
        #1;
        check("t3_busy_set", 64'(bus.busy_vec), 64'h80);
        check("t3_rs1_busy", 64'(bus.rs1_busy), 64'd1);
        check("t3_rs2_free", 64'(bus.rs2_busy), 64'd0);
        step();
        check("t3_rs1_still", 64'(bus.rs1_busy), 64'd1);
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd7;
        bus.lsu_data  = 64'hC0DE;
        #1;
        check("t3_lsu_ready", 64'(bus.lsu_ready), 64'd1);
        check("t3_rs1_xfer", 64'(bus.rs1_busy), 64'd1);
        step();
        bus.lsu_valid = 1'b0;
        #1;
        check("t3_busy_clr", 64'(bus.busy_vec), 64'd0);
        check("t3_wb_rd",    64'(bus.wb_rd),    64'd7);
        check("t3_rs1_wb",   64'(bus.rs1_busy), 64'd1);
        step();
        check("t3_rs1_done", 64'(bus.rs1_busy), 64'd0);

        // Set/clear collision on rd 9
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd9;
        step();
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd9;
        bus.lsu_data  = 64'h99;
        #1;
        check("t4_lsu_ready", 64'(bus.lsu_ready), 64'd1);
        step();
        idle_inputs();
        #1;
        check("t4_busy", 64'(bus.busy_vec), 64'h200);
        check("t4_wb_rd", 64'(bus.wb_rd), 64'd9);

        // Write to x0 is dropped but still handshakes
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd0;
        bus.alu_data  = 64'hFFFF;
        #1;
        check("t5_alu_ready", 64'(bus.alu_ready), 64'd1);
        step();
        bus.alu_valid = 1'b0;
        bus.rs1 = 5'd0;
        #1;
        check("t5_wb_en", 64'(bus.wb_en), 64'd0);
        check("t5_busy0", 64'(bus.busy_vec[0]), 64'd0);
        check("t5_rs1_x0", 64'(bus.rs1_busy), 64'd0);
        // The x0 transfer made ALU last_grant, so LSU wins this conflict
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd2;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd1;
        #1;
        check("t5_next_lsu", 64'(bus.lsu_ready), 64'd1);
        check("t5_next_alu", 64'(bus.alu_ready), 64'd0);
        idle_inputs();
        step();

        // Reset mid-operation with busy_vec = 0x480 and last_grant = LSU
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        step();
        bus.issue_rd  = 5'd10;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd9;
        bus.lsu_data  = 64'h5;
        step();
        bus.issue_valid = 1'b0;
        bus.lsu_rd      = 5'd12;
        bus.lsu_data    = 64'h77;
        #1;
        check("t6_busy_pre", 64'(bus.busy_vec), 64'h480);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("t6_busy_rst",  64'(bus.busy_vec), 64'd0);
        check("t6_wb_en_rst", 64'(bus.wb_en),    64'd0);
        check("t6_wb_rd_rst", 64'(bus.wb_rd),    64'd0);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd3;
        #1;
        check("t6_lsu_ready", 64'(bus.lsu_ready), 64'd1);
        check("t6_alu_ready", 64'(bus.alu_ready), 64'd0);
        step();
        idle_inputs();
        #1;
        check("t6_wb_rd", 64'(bus.wb_rd), 64'd12);
        check("t6_wb_data", bus.wb_data, 64'h77);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
- Write-back scheduler and scoreboard in front of the 32x64 integer register file.
- Arbitrates the register file's single write port (RD / RD_Back / Control) between the ALU result path and the LSU load-return path.
- Tracks which registers have an in-flight write, so decode can stall on RAW hazards.
- Sits between EXU/LSU and the register file; decode also queries its busy outputs.

Parameters:
- XLEN, 64, data width of a register.
- AW, 5, register index width (32 registers).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- issue_valid  in  1  decode issues an instruction that will write issue_rd.
- issue_rd  in  AW  destination register of the issued instruction.
- rs1  in  AW  decode source register 1 index.
- rs2  in  AW  decode source register 2 index.
- rs1_busy  out  1  rs1 has a pending write; decode must stall.
- rs2_busy  out  1  rs2 has a pending write; decode must stall.
- alu_valid  in  1  ALU result request.
- alu_ready  out  1  ALU request granted this cycle.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  XLEN  ALU result.
- lsu_valid  in  1  LSU load-return request.
- lsu_ready  out  1  LSU request granted this cycle.
- lsu_rd  in  AW  LSU destination register.
- lsu_data  in  XLEN  LSU load data.
- wb_en  out  1  register file write enable (drives Control).
- wb_rd  out  AW  register file write index (drives RD).
- wb_data  out  XLEN  register file write data (drives RD_Back).
- busy_vec  out  32  scoreboard state, bit i = register i busy.

Behaviour:
- Reset (rst=1 at posedge):
  - wb_en=0, wb_rd=0, wb_data=0, busy_vec=0.
  - last_grant=ALU, so the LSU wins the first conflict.
  - A reset during any handshake discards the in-flight write and clears all busy bits.
- Handshake:
  - Standard valid/ready; a transfer occurs when valid&&ready at the posedge.
  - Requesters hold rd/data stable while valid && !ready.
  - ready is combinational from the valid inputs and last_grant.
  - ready is never asserted without the matching valid.
- Arbitration:
  - One valid requester: it is granted.
  - Both valid: the requester that was not last_grant is granted (round-robin).
  - last_grant updates only on a completed transfer.
  - Neither valid: no grant, and last_grant holds.
- Write-back stage (registered, latency 1):
  - Transfer in cycle N gives wb_en=1 with the granted rd/data in cycle N+1; the register file updates at the end of N+1.
  - No transfer in cycle N gives wb_en=0 in N+1; wb_rd and wb_data hold their previous values.
  - rd=0: the handshake completes and last_grant updates, but wb_en=0 (writes to x0 are dropped).
- Scoreboard:
  - issue_valid with issue_rd!=0 sets busy[issue_rd] at the posedge.
  - A completed transfer (either port) clears busy[rd].
  - Simultaneous set and clear of the same rd: set wins, because the newer instruction owns the register.
  - issue to an already-busy rd: bit stays 1. Decode guarantees this does not happen; no error is flagged.
  - busy[0] is always 0.
- Hazard outputs:
  - rsX_busy = (rsX!=0) && (busy[rsX] || (wb_en && wb_rd==rsX)).
  - This covers data that is still in the write-back register and not yet in the register file.
  - Purely combinational from state and rsX; there is no path from the valid inputs.
- Throughput: one write per cycle sustained; with both requesters valid continuously, grants strictly alternate.

Test Plan:
1. Reset, then a single ALU request: alu_valid=1, alu_rd=5, alu_data=0x1234 -> alu_ready=1 that cycle; next cycle wb_en=1, wb_rd=5, wb_data=0x1234; the cycle after, wb_en=0.
2. Contention: alu and lsu both valid for 4 cycles, rd 3 and 4 -> grants LSU, ALU, LSU, ALU; wb_rd sequence 4,3,4,3.
3. Scoreboard: issue_valid with rd=7, then rs1=7 -> rs1_busy=1 until the LSU transfer for rd 7 completes, stays 1 for one more cycle while wb_rd=7 and wb_en=1, then drops to 0.
4. Set/clear collision: LSU completes rd=9 in the same cycle issue_valid sets rd=9 -> busy_vec[9]=1 afterwards.
5. x0: ALU request rd=0, data=0xFFFF -> alu_ready=1, wb_en stays 0, busy_vec[0]=0, rs1=0 gives rs1_busy=0.
6. Reset mid-operation: busy_vec=0x0000_0480 and lsu_valid=1 when rst is asserted for one cycle -> next cycle busy_vec=0, wb_en=0, and the next conflict is granted to the LSU.
